// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy/fill engine: FSM state encoding,
// transfer modes and the data-memory port ownership selects.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_t;

    localparam logic DMA_MODE_COPY = 1'b0;
    localparam logic DMA_MODE_FILL = 1'b1;

    // Same encoding as the data memory's ctrl_by selects.
    localparam logic CPU_CTRL = 1'b0;
    localparam logic DMA_CTRL = 1'b1;

endpackage

// File: rtl/dma_addr_gen.sv
// Source/destination word pointers and remaining-word counter for the DMA engine.
// Overlapping copies with dst inside (src, src+len) walk downwards to avoid clobbering.
module dma_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic                  copy_mode,
    input  logic [ADDR_WIDTH-1:0] src_word,
    input  logic [ADDR_WIDTH-1:0] dst_word,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] cur_src,
    output logic [ADDR_WIDTH-1:0] cur_dst,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  descending_q;

    logic [ADDR_WIDTH:0]   src_ext;
    logic [ADDR_WIDTH:0]   dst_ext;
    logic [ADDR_WIDTH:0]   len_ext;
    logic [ADDR_WIDTH-1:0] len_addr;
    logic                  descending;

    // One extra bit so src+len never wraps when judging overlap.
    assign src_ext    = {1'b0, src_word};
    assign dst_ext    = {1'b0, dst_word};
    assign len_ext    = (ADDR_WIDTH+1)'(len);
    assign len_addr   = ADDR_WIDTH'(len);
    assign descending = copy_mode && (src_ext < dst_ext) && (dst_ext < src_ext + len_ext);

    assign cur_src = src_q;
    assign cur_dst = dst_q;
    assign last    = (remaining_q == LEN_ONE);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            descending_q <= 1'b0;
        end else if (load) begin
            descending_q <= descending;
            remaining_q  <= len;
            if (descending) begin
                src_q <= src_word + len_addr - ADDR_ONE;
                dst_q <= dst_word + len_addr - ADDR_ONE;
            end else begin
                src_q <= src_word;
                dst_q <= dst_word;
            end
        end else if (step) begin
            remaining_q <= remaining_q - LEN_ONE;
            if (!last) begin
                if (descending_q) begin
                    src_q <= src_q - ADDR_ONE;
                    dst_q <= dst_q - ADDR_ONE;
                end else begin
                    src_q <= src_q + ADDR_ONE;
                    dst_q <= dst_q + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/dma_copy_engine.sv
// Word-granular DMA engine driving the DMA side of L1 data memory: block copy and
// constant fill, stalling the CPU while it owns the memory ports.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 128,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       dma_start,
    input  logic                       dma_mode,
    input  logic [DATA_ADDR_WIDTH-1:0] dma_src_word,
    input  logic [DATA_ADDR_WIDTH-1:0] dma_dst_word,
    input  logic [LEN_WIDTH-1:0]       dma_len,
    input  logic [DATA_WIDTH-1:0]      dma_fill_value,
    input  logic                       cpu_mem_busy,
    input  logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_raddr,
    output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_waddr,
    output logic [DATA_WIDTH-1:0]      dma_data_mem_wdata,
    output logic                       dma_data_mem_write,
    output logic                       data_mem_read_ctrl_by,
    output logic                       data_mem_write_ctrl_by,
    output logic                       cpu_stall,
    output logic                       dma_busy,
    output logic                       dma_done,
    output logic                       dma_error
);

    localparam logic [DATA_ADDR_WIDTH:0] MEM_LIMIT = (DATA_ADDR_WIDTH+1)'(NUM_WORDS);

    dma_state_t state_q, state_d;

    logic                       mode_q;
    logic [DATA_WIDTH-1:0]      fill_q;
    logic [DATA_WIDTH-1:0]      buf_q;
    logic                       error_q;

    logic                       accept;
    logic                       range_err;
    logic                       step;
    logic                       last;
    logic [DATA_ADDR_WIDTH-1:0] cur_src;
    logic [DATA_ADDR_WIDTH-1:0] cur_dst;
    logic [DATA_ADDR_WIDTH:0]   len_ext;
    logic [DATA_ADDR_WIDTH:0]   src_end;
    logic [DATA_ADDR_WIDTH:0]   dst_end;

    assign accept    = (state_q == ST_IDLE) && dma_start;
    assign step      = (state_q == ST_WRITE);
    assign len_ext   = (DATA_ADDR_WIDTH+1)'(dma_len);
    assign src_end   = {1'b0, dma_src_word} + len_ext;
    assign dst_end   = {1'b0, dma_dst_word} + len_ext;
    assign range_err = (dst_end > MEM_LIMIT) ||
                       ((dma_mode == DMA_MODE_COPY) && (src_end > MEM_LIMIT));
    assign dma_error = error_q;

    dma_addr_gen #(
        .ADDR_WIDTH (DATA_ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .cpu_clk    (cpu_clk),
        .cpu_rst_n  (cpu_rst_n),
        .load       (accept),
        .step       (step),
        .copy_mode  (dma_mode == DMA_MODE_COPY),
        .src_word   (dma_src_word),
        .dst_word   (dma_dst_word),
        .len        (dma_len),
        .cur_src    (cur_src),
        .cur_dst    (cur_dst),
        .last       (last)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request config and the copy data buffer.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            mode_q  <= DMA_MODE_COPY;
            fill_q  <= '0;
            buf_q   <= '0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                mode_q  <= dma_mode;
                fill_q  <= dma_fill_value;
                error_q <= range_err;
            end
            if (state_q == ST_READ) begin
                buf_q <= data_mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dma_start) begin
                    if (range_err || (dma_len == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_ARB: begin
                if (!cpu_mem_busy) begin
                    state_d = (mode_q == DMA_MODE_COPY) ? ST_READ : ST_WRITE;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (last) begin
                    state_d = ST_DONE;
                end else if (mode_q == DMA_MODE_COPY) begin
                    state_d = ST_READ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore decode: ARB holds the CPU off but leaves the ports with it until it is idle.
    always_comb begin
        dma_data_mem_raddr     = '0;
        dma_data_mem_waddr     = '0;
        dma_data_mem_wdata     = '0;
        dma_data_mem_write     = 1'b0;
        data_mem_read_ctrl_by  = CPU_CTRL;
        data_mem_write_ctrl_by = CPU_CTRL;
        cpu_stall              = 1'b0;
        dma_busy               = (state_q != ST_IDLE);
        dma_done               = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                cpu_stall = 1'b1;
            end
            ST_READ: begin
                cpu_stall             = 1'b1;
                data_mem_read_ctrl_by = DMA_CTRL;
                dma_data_mem_raddr    = cur_src;
            end
            ST_WRITE: begin
                cpu_stall              = 1'b1;
                data_mem_write_ctrl_by = DMA_CTRL;
                dma_data_mem_write     = 1'b1;
                dma_data_mem_waddr     = cur_dst;
                dma_data_mem_wdata     = (mode_q == DMA_MODE_FILL) ? fill_q : buf_q;
            end
            ST_DONE: begin
                dma_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Word-granular DMA engine that drives the DMA-side ports of the L1 data memory: dma read/write addresses, write data, write enable and the two ctrl_by selects.
- Performs two operations inside data memory:
  - copy: word block from src to dst;
  - fill: write a constant to a word block.
- Sits directly upstream of data memory, beside the CPU load/store path.
- Arbitrates ownership by stalling the CPU while it holds memory.

Parameters:
- DATA_WIDTH, 32, word width.
- DATA_ADDR_WIDTH, 32, word-address width on the DMA ports.
- NUM_WORDS, 128, data memory depth in words; used for range checking.
- LEN_WIDTH, 8, width of the transfer length in words.

Ports:
- cpu_clk  in  1  single clock.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- dma_start  in  1  one-cycle request; sampled only in IDLE.
- dma_mode  in  1  0 = copy, 1 = fill.
- dma_src_word  in  DATA_ADDR_WIDTH  source word index (copy only).
- dma_dst_word  in  DATA_ADDR_WIDTH  destination word index.
- dma_len  in  LEN_WIDTH  number of words.
- dma_fill_value  in  DATA_WIDTH  fill constant.
- cpu_mem_busy  in  1  CPU has a data-memory access in flight this cycle.
- data_mem_rdata  in  DATA_WIDTH  combinational read data from data memory.
- dma_data_mem_raddr  out  DATA_ADDR_WIDTH  DMA read word address.
- dma_data_mem_waddr  out  DATA_ADDR_WIDTH  DMA write word address.
- dma_data_mem_wdata  out  DATA_WIDTH  DMA write data.
- dma_data_mem_write  out  1  DMA write enable; the top level ORs it into data_mem_write.
- data_mem_read_ctrl_by  out  1  0 = CPU, 1 = DMA.
- data_mem_write_ctrl_by  out  1  0 = CPU, 1 = DMA.
- cpu_stall  out  1  CPU must hold its memory stage.
- dma_busy  out  1  high in every state except IDLE.
- dma_done  out  1  one-cycle completion pulse.
- dma_error  out  1  range error on the last accepted request; sticky until the next accepted start.

Behaviour:
- Reset (async, cpu_rst_n=0):
  - state IDLE;
  - all outputs 0;
  - config and data registers cleared.
  - Partially completed writes remain in memory.
- All outputs are Moore-decoded from registered state and pointers, so they are stable for the whole cycle.
- States: IDLE, ARB, READ, WRITE, DONE.
- IDLE:
  - On dma_start=1, latch mode/src/dst/len/fill and clear dma_error.
  - Range check uses DATA_ADDR_WIDTH+1-bit arithmetic, so no wrap.
  - Error if dst+len > NUM_WORDS, or (copy) src+len > NUM_WORDS. Then go to DONE with dma_error=1; no ownership taken, no writes.
  - len=0: go to DONE with dma_error=0.
  - Otherwise go to ARB.
- dma_start outside IDLE is ignored and not queued.
- Direction:
  - Descending if copy and src < dst < src+len. Pointers start at src+len-1 / dst+len-1 and decrement.
  - Otherwise ascending, including src==dst.
- ARB:
  - cpu_stall=1; ctrl_by both 0.
  - Leave when cpu_mem_busy=0: copy goes to READ, fill goes to WRITE.
  - Stays indefinitely while cpu_mem_busy=1.
- READ (copy only):
  - read_ctrl_by=1; raddr=cur_src.
  - On the edge, capture data_mem_rdata into the data buffer; go to WRITE.
- WRITE:
  - write_ctrl_by=1; dma_data_mem_write=1; waddr=cur_dst.
  - wdata = buffer (copy) or fill value (fill).
  - On the edge, remaining decrements.
  - If remaining was 1, go to DONE.
  - Otherwise step both pointers ±1, then go to READ (copy) or stay in WRITE (fill).
- DONE:
  - dma_done=1; cpu_stall=0; ctrl_by both 0.
  - Go to IDLE next cycle.
- cpu_stall=1 in ARB, READ and WRITE.
- Throughput: copy 2 cycles/word; fill 1 cycle/word.
- Latency from the start edge to the dma_done cycle, with CPU idle:
  - copy: 2 + 2N cycles;
  - fill: 2 + N cycles;
  - error or len=0: 1 cycle.
- The remaining counter is LEN_WIDTH bits, so the maximum transfer is 2^LEN_WIDTH-1 words.

Decomposition:
- Shared package dma_pkg holds:
  - state encoding;
  - DMA_MODE_COPY/DMA_MODE_FILL;
  - CPU_CTRL=0 and DMA_CTRL=1 (same encoding as data memory).
- Natural sub-module: dma_addr_gen, containing:
  - src/dst pointers, the remaining counter and the direction flag;
  - load/step/last outputs.
- The FSM and output decode stay in dma_copy_engine.

Test Plan:
- Fill, NUM_WORDS=128, mem preloaded 0: mode=1, dst=10, len=4, fill=32'hDEADBEEF, cpu_mem_busy=0 -> words 10..13 = DEADBEEF; words 9 and 14 = 0; dma_done 6 cycles after the start edge; write_ctrl_by high for exactly 4 cycles.
- Overlapping copy, forward overlap: mem[0..4]={1,2,3,4,5}, src=0, dst=2, len=3 -> descending order; mem[0..4]={1,2,1,2,3}; done at cycle 8.
- Overlapping copy, backward overlap: same preload, src=2, dst=0, len=3 -> ascending order; mem[0..4]={3,4,5,4,5}.
- Range error: dst=126, len=4 -> dma_error=1 and dma_done 1 cycle after start; ctrl_by, cpu_stall and dma_data_mem_write never assert; memory unchanged.
- Arbitration: cpu_mem_busy=1 for 5 cycles after start -> cpu_stall=1 and ctrl_by=0 throughout; the first READ occurs the cycle after cpu_mem_busy falls; a second dma_start during busy is ignored (exactly one dma_done).
- Reset mid-copy (src=0, dst=40, len=8; cpu_rst_n low after 3 words) -> all outputs 0 immediately; after release dma_busy=0 and words 40..42 hold the copied data.
